// File: rtl/camshift_track_if.sv
// Moment-engine job bus between the CamShift tracker (master) and the meanshift engine (slave).
interface camshift_track_if #(
    parameter int CW = 11
);
    logic          m_req;
    logic          m_abort;
    logic [CW-1:0] m_c_min;
    logic [CW-1:0] m_c_max;
    logic [CW-1:0] m_r_min;
    logic [CW-1:0] m_r_max;
    logic          m_done;
    logic [CW-1:0] m_x;
    logic [CW-1:0] m_y;
    logic [2*CW-1:0] m_00;

    modport master (
        output m_req, m_abort, m_c_min, m_c_max, m_r_min, m_r_max,
        input  m_done, m_x, m_y, m_00
    );

    modport slave (
        input  m_req, m_abort, m_c_min, m_c_max, m_r_min, m_r_max,
        output m_done, m_x, m_y, m_00
    );
endinterface

// File: rtl/camshift_track.sv
// CamShift window tracker: iterates the moment engine, sizes the window from isqrt(m_00).
// Define CAMSHIFT_AREA_EN to build the result-area multiplier; otherwise area reads 0.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | latch input window, seed centres, clear iteration count
// EXPAND | grow current window by (k+1)*GROW, clamped to frame
// REQ    | pulse m_req
// WAIT   | wait for m_done, take centroid
// CHECK  | convergence / iteration-limit decision
// SQRT   | bit-serial isqrt of m_00, CW cycles
// SCALE  | half-lengths from s
// CLAMP  | result window around centroid
// FAIL   | lost target, result is input window
// DONE   | results visible, done pulse
module camshift_track #(
    parameter int CW       = 11,
    parameter int MAX_ITER = 15,
    parameter int CONV_TH  = 1,
    parameter int GROW     = 1,
    parameter int KC       = 77,
    parameter int KR       = 92
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [CW-1:0]   c_min_i,
    input  logic [CW-1:0]   c_max_i,
    input  logic [CW-1:0]   r_min_i,
    input  logic [CW-1:0]   r_max_i,
    input  logic [CW-1:0]   frame_w,
    input  logic [CW-1:0]   frame_h,
    camshift_track_if.master eng,
    output logic [CW-1:0]   win_c_min,
    output logic [CW-1:0]   win_c_max,
    output logic [CW-1:0]   win_r_min,
    output logic [CW-1:0]   win_r_max,
    output logic [CW-1:0]   cen_x,
    output logic [CW-1:0]   cen_y,
    output logic [2*CW-1:0] area,
    output logic [CW-1:0]   iter_cnt,
    output logic            converged,
    output logic            lost,
    output logic            busy,
    output logic            done
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_EXPAND, S_REQ, S_WAIT, S_CHECK,
        S_SQRT, S_SCALE, S_CLAMP, S_FAIL, S_DONE
    } state_t;

    localparam logic [CW-1:0]   MAX_ITER_C = CW'(MAX_ITER);
    localparam logic [CW-1:0]   CONV_TH_C  = CW'(CONV_TH);
    localparam logic [2*CW-1:0] GROW_C     = (2*CW)'(GROW);
    localparam logic [CW+6:0]   KC_C       = (CW+7)'(KC);
    localparam logic [CW+6:0]   KR_C       = (CW+7)'(KR);

    state_t state, state_nx;

    logic [CW-1:0]   in_c_min, in_c_max, in_r_min, in_r_max;
    logic [CW-1:0]   cur_c_min, cur_c_max, cur_r_min, cur_r_max;
    logic [CW-1:0]   old_x, old_y, new_x, new_y, k;
    logic            conv;
    logic [2*CW-1:0] rad;
    logic [CW+1:0]   rem;
    logic [CW-1:0]   root, sq_cnt, hc, hr;

    logic            req, abort, is_conv, res_load;
    logic [2*CW-1:0] d_exp;
    logic [CW-1:0]   dx, dy;
    logic [CW+3:0]   rem_t, trial;
    logic [CW+6:0]   prod_c, prod_r;
    logic [CW-1:0]   res_c_min, res_c_max, res_r_min, res_r_max, res_x, res_y;

    function automatic logic [CW-1:0] mid(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return CW'(s >> 1);
    endfunction

    function automatic logic [CW-1:0] clamp_lo(input logic [CW-1:0] v, input logic [2*CW-1:0] d);
        logic [2*CW-1:0] ve;
        ve = {{CW{1'b0}}, v};
        return (ve >= d) ? CW'(ve - d) : '0;
    endfunction

    function automatic logic [CW-1:0] clamp_hi(input logic [CW-1:0] v, input logic [2*CW-1:0] d,
                                               input logic [CW-1:0] f);
        logic [2*CW-1:0] s;
        s = {{CW{1'b0}}, v} + d;
        return (s < {{CW{1'b0}}, f}) ? CW'(s) : f - 1'b1;
    endfunction

    assign d_exp   = ({{CW{1'b0}}, k} + (2*CW)'(1)) * GROW_C;
    assign dx      = (new_x >= old_x) ? new_x - old_x : old_x - new_x;
    assign dy      = (new_y >= old_y) ? new_y - old_y : old_y - new_y;
    assign is_conv = (dx <= CONV_TH_C) && (dy <= CONV_TH_C);
    assign rem_t   = {rem, rad[2*CW-1 -: 2]};
    assign trial   = {2'b00, root, 2'b01};
    assign prod_c  = {7'b0, root} * KC_C;
    assign prod_r  = {7'b0, root} * KR_C;
    assign res_load = !start && (state == S_CLAMP || state == S_FAIL);
    assign busy    = (state != S_IDLE);

    assign eng.m_req   = req;
    assign eng.m_abort = abort;
    assign eng.m_c_min = cur_c_min;
    assign eng.m_c_max = cur_c_max;
    assign eng.m_r_min = cur_r_min;
    assign eng.m_r_max = cur_r_max;

    always_comb begin
        res_c_min = clamp_lo(new_x, {{CW{1'b0}}, hc});
        res_c_max = clamp_hi(new_x, {{CW{1'b0}}, hc}, frame_w);
        res_r_min = clamp_lo(new_y, {{CW{1'b0}}, hr});
        res_r_max = clamp_hi(new_y, {{CW{1'b0}}, hr}, frame_h);
        res_x     = new_x;
        res_y     = new_y;
        if (state == S_FAIL) begin
            res_c_min = in_c_min;
            res_c_max = in_c_max;
            res_r_min = in_r_min;
            res_r_max = in_r_max;
            res_x     = mid(in_c_min, in_c_max);
            res_y     = mid(in_r_min, in_r_max);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // start wins over everything, including a coincident m_done
    always_comb begin
        state_nx = state;
        req      = 1'b0;
        abort    = 1'b0;
        if (start) begin
            state_nx = S_LOAD;
            abort    = (state != S_IDLE);
        end else begin
            case (state)
                S_IDLE:   state_nx = S_IDLE;
                S_LOAD:   state_nx = S_EXPAND;
                S_EXPAND: state_nx = S_REQ;
                S_REQ: begin
                    req      = 1'b1;
                    state_nx = S_WAIT;
                end
                S_WAIT:   if (eng.m_done) state_nx = (eng.m_00 == '0) ? S_FAIL : S_CHECK;
                S_CHECK:  state_nx = (is_conv || k == MAX_ITER_C) ? S_SQRT : S_EXPAND;
                S_SQRT:   if (sq_cnt == '0) state_nx = S_SCALE;
                S_SCALE:  state_nx = S_CLAMP;
                S_CLAMP:  state_nx = S_DONE;
                S_FAIL:   state_nx = S_DONE;
                S_DONE:   state_nx = S_IDLE;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {in_c_min, in_c_max, in_r_min, in_r_max}     <= '0;
            {cur_c_min, cur_c_max, cur_r_min, cur_r_max} <= '0;
            {old_x, old_y, new_x, new_y, k}              <= '0;
            conv   <= 1'b0;
            rad    <= '0;
            rem    <= '0;
            root   <= '0;
            sq_cnt <= '0;
            hc     <= '0;
            hr     <= '0;
        end else if (start) begin
            in_c_min <= c_min_i;
            in_c_max <= c_max_i;
            in_r_min <= r_min_i;
            in_r_max <= r_max_i;
        end else begin
            case (state)
                S_LOAD: begin
                    cur_c_min <= in_c_min;
                    cur_c_max <= in_c_max;
                    cur_r_min <= in_r_min;
                    cur_r_max <= in_r_max;
                    old_x <= mid(in_c_min, in_c_max);
                    new_x <= mid(in_c_min, in_c_max);
                    old_y <= mid(in_r_min, in_r_max);
                    new_y <= mid(in_r_min, in_r_max);
                    k     <= '0;
                end
                S_EXPAND: begin
                    cur_c_min <= clamp_lo(cur_c_min, d_exp);
                    cur_c_max <= clamp_hi(cur_c_max, d_exp, frame_w);
                    cur_r_min <= clamp_lo(cur_r_min, d_exp);
                    cur_r_max <= clamp_hi(cur_r_max, d_exp, frame_h);
                end
                S_WAIT: if (eng.m_done) begin
                    k <= k + 1'b1;
                    if (eng.m_00 != '0) begin
                        old_x <= new_x;
                        old_y <= new_y;
                        new_x <= eng.m_x;
                        new_y <= eng.m_y;
                    end
                    rad    <= eng.m_00;
                    rem    <= '0;
                    root   <= '0;
                    sq_cnt <= CW'(CW - 1);
                end
                S_CHECK: conv <= is_conv;
                S_SQRT: begin
                    rad    <= rad << 2;
                    sq_cnt <= sq_cnt - 1'b1;
                    if (rem_t >= trial) begin
                        rem  <= (CW+2)'(rem_t - trial);
                        root <= {root[CW-2:0], 1'b1};
                    end else begin
                        rem  <= (CW+2)'(rem_t);
                        root <= {root[CW-2:0], 1'b0};
                    end
                end
                S_SCALE: begin
                    hc <= CW'(prod_c >> 7);
                    hr <= CW'(prod_r >> 7);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {win_c_min, win_c_max, win_r_min, win_r_max} <= '0;
            {cen_x, cen_y, iter_cnt}                     <= '0;
            converged <= 1'b0;
            lost      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= res_load;
            if (res_load) begin
                win_c_min <= res_c_min;
                win_c_max <= res_c_max;
                win_r_min <= res_r_min;
                win_r_max <= res_r_max;
                cen_x     <= res_x;
                cen_y     <= res_y;
                iter_cnt  <= k;
                converged <= (state == S_CLAMP) && conv;
                lost      <= (state == S_FAIL);
            end
        end
    end

`ifdef CAMSHIFT_AREA_EN
    logic [CW:0]     span_c, span_r;
    logic [2*CW-1:0] area_nx;

    assign span_c  = {1'b0, res_c_max} - {1'b0, res_c_min} + 1'b1;
    assign span_r  = {1'b0, res_r_max} - {1'b0, res_r_min} + 1'b1;
    assign area_nx = {{(CW-1){1'b0}}, span_c} * {{(CW-1){1'b0}}, span_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        area <= '0;
        else if (res_load) area <= area_nx;
    end
`else
    assign area = '0;
`endif
endmodule

// File: tb/tb_camshift_track.sv
// Randomised self-checking bench for camshift_track against an integer reference model.
module tb_camshift_track;
    localparam int CW = 11;
    localparam int MAX_ITER = 15, CONV_TH = 1, GROW = 1, KC = 77, KR = 92;

    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic [CW-1:0] c_min_i = '0, c_max_i = '0, r_min_i = '0, r_max_i = '0;
    logic [CW-1:0] frame_w = '0, frame_h = '0;
    logic [CW-1:0] win_c_min, win_c_max, win_r_min, win_r_max, cen_x, cen_y, iter_cnt;
    logic [2*CW-1:0] area;
    logic converged, lost, busy, done;

    camshift_track_if #(.CW(CW)) bus ();

    camshift_track #(.CW(CW), .MAX_ITER(MAX_ITER), .CONV_TH(CONV_TH), .GROW(GROW),
                     .KC(KC), .KR(KR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .c_min_i(c_min_i), .c_max_i(c_max_i), .r_min_i(r_min_i), .r_max_i(r_max_i),
        .frame_w(frame_w), .frame_h(frame_h), .eng(bus),
        .win_c_min(win_c_min), .win_c_max(win_c_max), .win_r_min(win_r_min),
        .win_r_max(win_r_max), .cen_x(cen_x), .cen_y(cen_y), .area(area),
        .iter_cnt(iter_cnt), .converged(converged), .lost(lost), .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int ic0, ic1, ir0, ir1, fw, fh, lat;
    int rx[16], ry[16], rm[16];
    int gen = 0, stale_en = 0;
    int lw_c0[16], lw_c1[16], lw_r0[16], lw_r1[16];
    int eng_idx = 0, dn_cnt = 0;
    int e_c0, e_c1, e_r0, e_r1, e_cx, e_cy, e_iter, e_conv, e_lost, e_lat, e_area;
    int ew_c0[16], ew_c1[16], ew_r0[16], ew_r1[16];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // engine model: answers each m_req after lat cycles; a new track (gen change) drops its job
    initial begin
        int cnt, jidx, sgen;
        cnt = 0; jidx = 0; sgen = 0;
        bus.m_done = 1'b0; bus.m_x = '0; bus.m_y = '0; bus.m_00 = '0;
        forever begin
            @(negedge clk);
            bus.m_done = 1'b0;
            if (sgen != gen) begin
                sgen = gen; cnt = 0; eng_idx = 0;
                if (stale_en != 0) begin
                    bus.m_done = 1'b1; bus.m_x = CW'(300); bus.m_y = CW'(300); bus.m_00 = 50;
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.m_done = 1'b1;
                    bus.m_x = CW'(rx[jidx]); bus.m_y = CW'(ry[jidx]);
                    bus.m_00 = (2*CW)'(rm[jidx]);
                end
            end
            if (bus.m_req && eng_idx < 16) begin
                lw_c0[eng_idx] = bus.m_c_min; lw_c1[eng_idx] = bus.m_c_max;
                lw_r0[eng_idx] = bus.m_r_min; lw_r1[eng_idx] = bus.m_r_max;
                jidx = eng_idx; eng_idx++; cnt = lat;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) dn_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int isqrt(input longint n);
        longint s = 0;
        while ((s + 1) * (s + 1) <= n) s++;
        return int'(s);
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model();
        int c0 = ic0, c1 = ic1, r0 = ir0, r1 = ir1;
        int nx, ny, ox, oy, k, d, s, hc, hr, m;
        nx = (ic0 + ic1) / 2; ny = (ir0 + ir1) / 2;
        k = 0; m = 0; e_conv = 0; e_lost = 0;
        forever begin
            d  = (k + 1) * GROW;
            c0 = (c0 >= d) ? c0 - d : 0;
            c1 = (c1 + d < fw) ? c1 + d : fw - 1;
            r0 = (r0 >= d) ? r0 - d : 0;
            r1 = (r1 + d < fh) ? r1 + d : fh - 1;
            ew_c0[k] = c0; ew_c1[k] = c1; ew_r0[k] = r0; ew_r1[k] = r1;
            if (rm[k] == 0) begin e_lost = 1; k++; break; end
            ox = nx; oy = ny; nx = rx[k]; ny = ry[k]; m = rm[k]; k++;
            if (absd(nx, ox) <= CONV_TH && absd(ny, oy) <= CONV_TH) begin e_conv = 1; break; end
            if (k == MAX_ITER) break;
        end
        e_iter = k;
        if (e_lost != 0) begin
            e_c0 = ic0; e_c1 = ic1; e_r0 = ir0; e_r1 = ir1;
            e_cx = (ic0 + ic1) / 2; e_cy = (ir0 + ir1) / 2;
            e_lat = 5 + lat + (k - 1) * (3 + lat);
        end else begin
            s = isqrt(m); hc = (s * KC) / 128; hr = (s * KR) / 128;
            e_cx = nx; e_cy = ny;
            e_c0 = (nx >= hc) ? nx - hc : 0;
            e_c1 = (nx + hc < fw) ? nx + hc : fw - 1;
            e_r0 = (ny >= hr) ? ny - hr : 0;
            e_r1 = (ny + hr < fh) ? ny + hr : fh - 1;
            e_lat = 4 + lat + (k - 1) * (3 + lat) + CW + 3;
        end
`ifdef CAMSHIFT_AREA_EN
        e_area = (e_c1 - e_c0 + 1) * (e_r1 - e_r0 + 1);
`else
        e_area = 0;
`endif
    endtask

    task automatic finish_track(input string nm, input int cyc0, input int dn0);
        int cyc = cyc0;
        while (done !== 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
        chk({nm, ".latency"}, cyc, e_lat);
        chk({nm, ".win_c_min"}, win_c_min, e_c0);
        chk({nm, ".win_c_max"}, win_c_max, e_c1);
        chk({nm, ".win_r_min"}, win_r_min, e_r0);
        chk({nm, ".win_r_max"}, win_r_max, e_r1);
        chk({nm, ".cen_x"}, cen_x, e_cx);
        chk({nm, ".cen_y"}, cen_y, e_cy);
        chk({nm, ".area"}, area, e_area);
        chk({nm, ".iter_cnt"}, iter_cnt, e_iter);
        chk({nm, ".converged"}, converged, e_conv);
        chk({nm, ".lost"}, lost, e_lost);
        repeat (3) @(negedge clk);
        chk({nm, ".done_count"}, dn_cnt - dn0, 1);
        chk({nm, ".busy_after"}, busy, 0);
        chk({nm, ".engine_runs"}, eng_idx, e_iter);
        for (int i = 0; i < e_iter && i < eng_idx; i++) begin
            chk($sformatf("%s.run%0d.c_min", nm, i), lw_c0[i], ew_c0[i]);
            chk($sformatf("%s.run%0d.c_max", nm, i), lw_c1[i], ew_c1[i]);
            chk($sformatf("%s.run%0d.r_min", nm, i), lw_r0[i], ew_r0[i]);
            chk($sformatf("%s.run%0d.r_max", nm, i), lw_r1[i], ew_r1[i]);
        end
    endtask

    task automatic drive_start();
        c_min_i = CW'(ic0); c_max_i = CW'(ic1); r_min_i = CW'(ir0); r_max_i = CW'(ir1);
        frame_w = CW'(fw); frame_h = CW'(fh);
        start = 1'b1;
    endtask

    task automatic run_track(input string nm);
        int dn0;
        model();
        dn0 = dn_cnt;
        @(negedge clk);
        gen++;
        drive_start();
        #1 chk({nm, ".abort_idle"}, bus.m_abort, 0);
        @(negedge clk);
        start = 1'b0;
        finish_track(nm, 1, dn0);
    endtask

    task automatic set_scn(input int w0, input int w1, input int x, input int m00);
        fw = 640; fh = 480; ic0 = w0; ic1 = w1; ir0 = w0; ir1 = w1; lat = 3;
        for (int i = 0; i < 16; i++) begin rx[i] = x; ry[i] = x; rm[i] = m00; end
    endtask

    task automatic rand_setup();
        int cx, cy, v;
        fw = $urandom_range(64, 2047); fh = $urandom_range(64, 2047);
        ic0 = $urandom_range(0, fw - 2);
        ic1 = $urandom_range(ic0, (ic0 + 300 < fw - 1) ? ic0 + 300 : fw - 1);
        ir0 = $urandom_range(0, fh - 2);
        ir1 = $urandom_range(ir0, (ir0 + 300 < fh - 1) ? ir0 + 300 : fh - 1);
        lat = $urandom_range(1, 6);
        cx = $urandom_range(0, fw - 1); cy = $urandom_range(0, fh - 1);
        for (int i = 0; i < 16; i++) begin
            v = cx + int'($urandom_range(0, 4)) - 2;
            rx[i] = (v < 0) ? 0 : (v > fw - 1) ? fw - 1 : v;
            v = cy + int'($urandom_range(0, 4)) - 2;
            ry[i] = (v < 0) ? 0 : (v > fh - 1) ? fh - 1 : v;
            rm[i] = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 4194303));
        end
    endtask

    initial begin
        int dn0, w;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.win_c_max", win_c_max, 0);
        chk("reset.area", area, 0);
        chk("reset.m_req", bus.m_req, 0);
        rst_n = 1'b1;

        set_scn(100, 139, 119, 1600);
        run_track("plan1");
        chk("plan1.eng_c_min", lw_c0[0], 99);
        chk("plan1.eng_c_max", lw_c1[0], 140);
        chk("plan1.res_c_min", win_c_min, 95);
        chk("plan1.res_r_max", win_r_max, 147);

        set_scn(0, 19, 5, 1600);
        run_track("plan2");
        chk("plan2.eng_c_max", lw_c1[0], 20);
        chk("plan2.res_c_max", win_c_max, 29);
        chk("plan2.res_r_max", win_r_max, 33);

        set_scn(100, 139, 119, 1600);
        for (int i = 0; i < 16; i++) begin rx[i] = 124 + 5 * i; ry[i] = 124 + 5 * i; end
        run_track("noconv");
        chk("noconv.iter_const", iter_cnt, 15);
        chk("noconv.conv_const", converged, 0);

        set_scn(100, 139, 119, 1600);
        rm[0] = 0;
        run_track("lost");
        chk("lost.flag_const", lost, 1);
        chk("lost.cen_const", cen_x, 119);

        // restart from WAIT with a stale m_done slipped in before the new request
        set_scn(100, 139, 119, 1600);
        lat = 20;
        dn0 = dn_cnt;
        @(negedge clk);
        gen++;
        drive_start();
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (eng_idx < 1 && w < 50) begin @(negedge clk); w++; end
        chk("abort.first_req", eng_idx, 1);
        repeat (2) @(negedge clk);
        lat = 3;
        model();
        stale_en = 1;
        gen++;
        start = 1'b1;
        #1 chk("abort.m_abort", bus.m_abort, 1);
        @(negedge clk);
        start = 1'b0;
        #1 chk("abort.no_req_t1", bus.m_req, 0);
        @(negedge clk);
        #1 chk("abort.no_req_t2", bus.m_req, 0);
        @(negedge clk);
        #1 chk("abort.req_t3", bus.m_req, 1);
        stale_en = 0;
        finish_track("abort", 3, dn0);

        // reset while in SQRT
        set_scn(100, 139, 119, 1600);
        lat = 2;
        dn0 = dn_cnt;
        @(negedge clk);
        gen++;
        drive_start();
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_sqrt.busy", busy, 0);
        chk("rst_sqrt.win_c_min", win_c_min, 0);
        chk("rst_sqrt.win_r_max", win_r_max, 0);
        chk("rst_sqrt.cen_x", cen_x, 0);
        chk("rst_sqrt.area", area, 0);
        chk("rst_sqrt.iter_cnt", iter_cnt, 0);
        chk("rst_sqrt.converged", converged, 0);
        chk("rst_sqrt.m_abort", bus.m_abort, 0);
        repeat (2) @(negedge clk);
        chk("rst_sqrt.no_done", dn_cnt - dn0, 0);
        rst_n = 1'b1;
        set_scn(100, 139, 119, 1600);
        run_track("after_rst");

        for (int t = 0; t < 30; t++) begin
            rand_setup();
            run_track($sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/camshift_track.md
# camshift_track

Parametrised CamShift window-tracking controller for the object-tracking pipeline. It iterates an external moment engine (meanshift) over a growing search window until the centroid converges or an iteration limit is reached. It then derives a new window size from the zeroth moment with an internal sequential integer square root, and outputs a frame-clamped window, centre and area. Unlike the fixed predecessor, it adds:
- generic coordinate width, iteration limit, convergence threshold and aspect factors;
- a both-axis convergence test;
- lost-target reporting;
- a restart/abort handshake to the engine.

## Interface
- CW, 11, coordinate width (frame up to 2^CW-1)
- MAX_ITER, 15, maximum moment-engine runs per track (1..2^CW-1)
- CONV_TH, 1, convergence threshold in pixels
- GROW, 1, per-iteration expansion step multiplier
- KC, 77, column half-length factor, Q6
- KR, 92, row half-length factor, Q6
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse: begin tracking; accepted in any state
- c_min_i, c_max_i, r_min_i, r_max_i  in  CW  initial window (sampled on start)
- frame_w, frame_h  in  CW  frame size (static during a track)
- m_req  out  1  one-cycle pulse: engine job request
- m_abort  out  1  one-cycle pulse: drop outstanding engine job
- m_c_min, m_c_max, m_r_min, m_r_max  out  CW  engine window; stable from m_req until m_done
- m_done  in  1  one-cycle pulse: engine result valid
- m_x, m_y  in  CW  engine centroid
- m_00  in  2*CW  engine zeroth moment
- win_c_min, win_c_max, win_r_min, win_r_max  out  CW  result window, reset 0
- cen_x, cen_y  out  CW  result centre, reset 0
- area  out  2*CW  result window area, reset 0
- iter_cnt  out  CW  engine runs used, reset 0
- converged, lost  out  1  result flags, reset 0
- busy  out  1  high outside IDLE, reset 0
- done  out  1  one-cycle pulse: results updated, reset 0

## Operation
FSM states and transitions:
- IDLE: on start → LOAD.
- LOAD: latch the input window; old centre := new centre := input window midpoint ((min+max)>>1, computed in CW+1 bits); k := 0 → EXPAND.
- EXPAND: grow each side by d = (k+1)*GROW. min := (min ≥ d) ? min−d : 0; max := (max + d < frame_dim) ? max+d : frame_dim−1. The first expansion applies to the input window; later ones apply to the current window. → REQ.
- REQ: pulse m_req → WAIT.
- WAIT: on m_done, with k := k+1:
  - m_00 == 0 → FAIL.
  - Otherwise old := new, new := (m_x, m_y) → CHECK.
- CHECK: convergence test on dx = |new_x−old_x| and dy = |new_y−old_y|.
  - dx ≤ CONV_TH and dy ≤ CONV_TH → SQRT with converged = 1.
  - Else if k == MAX_ITER → SQRT with converged = 0.
  - Else → EXPAND.
- SQRT: restoring bit-serial isqrt of the latched m_00. Takes exactly CW cycles and yields a CW-bit floor result s. → SCALE.
- SCALE: hc = (s*KC)>>7 and hr = (s*KR)>>7, i.e. /64 then halved. The products are CW+7 bits wide. → CLAMP.
- CLAMP: window = centre ± half, with the same clamp rules as EXPAND; centre = new. → DONE.
- FAIL: lost = 1, converged = 0; the result window is the input window, the centre is its midpoint. → DONE.
- DONE: register all results, pulse done → IDLE.

Further rules:
- area = (c_max−c_min+1)*(r_max−r_min+1) of the result window.
- start outside IDLE: pulse m_abort in the same cycle and restart at LOAD. Result outputs hold their previous values until the next done.
- m_done is ignored in every state except WAIT.
- start and m_done in the same cycle: start wins and the m_done is discarded.

## Timing
- start at cycle 0: LOAD at 1, EXPAND at 2, m_req at 3.
- Engine latency L: m_done at 3+L, CHECK at 4+L.
- Each further iteration costs 3+L cycles (EXPAND, REQ, WAIT, CHECK).
- After the final CHECK: SQRT CW cycles, SCALE 1, CLAMP 1. done is high CW+3 cycles after the final CHECK cycle.
- Single converging iteration with CW=11: done at cycle L+18.
- FAIL path: done 2 cycles after m_done.
- Reset mid-operation: all outputs go to their reset values immediately, FSM → IDLE, no m_abort is issued.

## Configuration
- CAMSHIFT_AREA_EN defined: the area multiplier is present and area behaves as specified.
- CAMSHIFT_AREA_EN undefined: the multiplier is removed, area is tied to 0, and all other behaviour is unchanged.

## Test plan
- frame 640x480, window c/r 100..139, engine returns x=y=119, m_00=1600.
  - Engine window c/r 99..140.
  - Result c 95..143, r 91..147, cen 119/119, area 2793, iter_cnt 1, converged 1.
- Window c/r 0..19, engine x=y=5, m_00=1600.
  - Engine window c/r 0..20.
  - Result c 0..29, r 0..33, area 1020.
- Engine centroid moves +5 per run: after 15 runs converged = 0, iter_cnt = 15, done exactly once.
- m_00 = 0 on the first run → lost = 1, result equals the input window, cen 119/119 (first scenario's window).
- start pulse in WAIT → m_abort the same cycle, m_req 3 cycles later. A stale m_done issued between these is ignored, and there is no done for the aborted track.
- rst_n low in SQRT → all outputs 0 and busy 0 while in reset; the next start behaves as the first scenario.
